// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or write, waits WAIT_CYCLES+1 cycles,
// commits the access to a DEPTH-word RAM and pulses mem_ready with status flags.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err,
    output logic              rw_clash
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_N  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              is_wr_p0;
    logic              clash_p0;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              req;
    logic              accept;
    logic              commit;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign req      = memread | memwrite;
    assign accept   = req && (state == S_IDLE || state == S_RESP);
    assign commit   = (state == S_WAIT) && (cnt == WAIT_N);
    assign in_range = ({1'b0, addr_p0} < DEPTH_X);
    assign idx      = addr_p0[IDX_W-1:0];

    // Accept stage: request fields captured here are the only ones the commit sees
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            is_wr_p0 <= memwrite;
            clash_p0 <= memread & memwrite;
        end
    end

    // Commit stage: storage is not reset, so a reset simply suppresses the write
    always_ff @(posedge clk) begin
        if (commit && is_wr_p0 && in_range) begin
            mem[idx] <= wdata_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            addr_err  <= 1'b0;
            rw_clash  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            rw_clash  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        addr_err  <= ~in_range;
                        rw_clash  <= clash_p0;
                        if (!is_wr_p0) begin
                            rdata <= in_range ? mem[idx] : '0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    // A request still high here starts the next transaction back-to-back
                    if (req) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
